// File: rtl/alu_fp_arbiter.sv
// Round-robin arbiter sharing one alu_fp between NUM_REQ issue lanes.
// Optional build macro ALU_FP_ARB_STICKY_V_EN adds per-requester sticky overflow flags.
module alu_fp_arbiter #(
  parameter int N       = 24,
  parameter int NUM_REQ = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*N-1:0]   req_a,
  input  logic [NUM_REQ*N-1:0]   req_b,
  input  logic [NUM_REQ*3-1:0]   req_op,
  output logic [N-1:0]           alu_a,
  output logic [N-1:0]           alu_b,
  output logic [2:0]             alu_ctrl,
  input  logic [N-1:0]           alu_result,
  input  logic [3:0]             alu_flags,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [N-1:0]           rsp_result,
  output logic [3:0]             rsp_flags,
`ifdef ALU_FP_ARB_STICKY_V_EN
  output logic [NUM_REQ-1:0]     sticky_v,
  input  logic [NUM_REQ-1:0]     sticky_clr,
`endif
  output logic                   busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N-1:0]    iss_a_q, iss_a_d;
  logic [N-1:0]    iss_b_q, iss_b_d;
  logic [2:0]      iss_op_q, iss_op_d;
  logic [ID_W-1:0] iss_id_q, iss_id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [N-1:0]    rsp_result_q, rsp_result_d;
  logic [3:0]      rsp_flags_q, rsp_flags_d;

  logic            grant_found;
  logic [ID_W-1:0] grant_id;
  logic            can_accept;
  logic            accept;

  // Search starts one past the last grant, so the last winner has lowest priority.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant_found && req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  // Gated by rst_n so nothing is offered while reset is being applied.
  assign can_accept = rst_n && ((state_q == S_IDLE) || ((state_q == S_HOLD) && rsp_ready));
  assign accept     = can_accept && grant_found;
  assign req_ready  = accept ? (NUM_REQ'(1) << grant_id) : '0;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    iss_a_d      = iss_a_q;
    iss_b_d      = iss_b_q;
    iss_op_d     = iss_op_q;
    iss_id_d     = iss_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;

    case (state_q)
      S_IDLE: if (accept) state_d = S_EXEC;
      S_EXEC: begin
        state_d      = S_HOLD;
        rsp_valid_d  = 1'b1;
        rsp_id_d     = iss_id_q;
        rsp_result_d = alu_result;
        rsp_flags_d  = alu_flags;
      end
      S_HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = accept ? S_EXEC : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      rr_ptr_d = grant_id;
      iss_a_d  = req_a[int'(grant_id)*N +: N];
      iss_b_d  = req_b[int'(grant_id)*N +: N];
      iss_op_d = req_op[int'(grant_id)*3 +: 3];
      iss_id_d = grant_id;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: synchronous reset; all state registers use non-blocking assignments.
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= ID_W'(NUM_REQ - 1);
      iss_a_q      <= '0;
      iss_b_q      <= '0;
      iss_op_q     <= '0;
      iss_id_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      iss_a_q      <= iss_a_d;
      iss_b_q      <= iss_b_d;
      iss_op_q     <= iss_op_d;
      iss_id_q     <= iss_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

`ifdef ALU_FP_ARB_STICKY_V_EN
  logic [NUM_REQ-1:0] sticky_q, sticky_d, sticky_set;

  // Set has priority over a same-cycle clear so no overflow is lost.
  assign sticky_set = ((state_q == S_EXEC) && alu_flags[1]) ? (NUM_REQ'(1) << iss_id_q) : '0;
  assign sticky_d   = (sticky_q & ~sticky_clr) | sticky_set;

  always_ff @(posedge clk) begin
    if (!rst_n) sticky_q <= '0;
    else        sticky_q <= sticky_d;
  end

  assign sticky_v = sticky_q;
`endif

  assign alu_a      = iss_a_q;
  assign alu_b      = iss_b_q;
  assign alu_ctrl   = iss_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_fp_arbiter.sv
// Directed bench for alu_fp_arbiter with a 16-bit sign-magnitude 8.8 alu_fp model
// driving alu_result/alu_flags from the arbiter's issue outputs.
module tb_alu_fp_arbiter;

  localparam int W  = 16;
  localparam int NR = 4;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*W-1:0] req_a;
  logic [NR*W-1:0] req_b;
  logic [NR*3-1:0] req_op;
  logic [W-1:0]    alu_a;
  logic [W-1:0]    alu_b;
  logic [2:0]      alu_ctrl;
  logic [W-1:0]    alu_result;
  logic [3:0]      alu_flags;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [W-1:0]    rsp_result;
  logic [3:0]      rsp_flags;
  logic            busy;

  int total = 0;
  int bad   = 0;

  alu_fp_arbiter #(.N(W), .NUM_REQ(NR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural alu_fp: ADD for every code except MUL (3'b010); flags {N,Z,V,C}.
  logic          sa, sb, sgn, v, c;
  logic [W-2:0]  ma, mb, mag;
  logic [W-1:0]  sum;
  logic [2*W-3:0] prod;
  always_comb begin
    sa = alu_a[W-1]; sb = alu_b[W-1];
    ma = alu_a[W-2:0]; mb = alu_b[W-2:0];
    sum = '0; prod = '0; mag = '0; sgn = 1'b0; v = 1'b0; c = 1'b0;
    if (alu_ctrl == 3'b010) begin
      prod = ma * mb;
      mag  = prod[W+6:8];
      v    = |prod[2*W-3:W+7];
      sgn  = sa ^ sb;
    end else if (sa == sb) begin
      sum = {1'b0, ma} + {1'b0, mb};
      mag = sum[W-2:0];
      c   = sum[W-1];
      v   = sum[W-1];
      sgn = sa;
    end else if (ma >= mb) begin
      mag = ma - mb; sgn = sa;
    end else begin
      mag = mb - ma; sgn = sb;
    end
    if (mag == '0) sgn = 1'b0;
    alu_result = {sgn, mag};
    alu_flags  = {sgn, (mag == '0), v, c};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_all_operands();
    for (int i = 0; i < NR; i++) begin
      req_a[i*W +: W] = W'(16'h0100 * (i + 1));
      req_b[i*W +: W] = W'(16'h0010 * (i + 1));
      req_op[i*3 +: 3] = (i == 2) ? 3'b111 : 3'b000;
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 4'hF; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0;

    // Reset held with all requests pending.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
    end
    check("rst_rsp_id", 32'(rsp_id), 32'h0);
    check("rst_rsp_result", 32'(rsp_result), 32'h0);
    check("rst_alu_a", 32'(alu_a), 32'h0);
    check("rst_alu_ctrl", 32'(alu_ctrl), 32'h0);

    // Single ADD from requester 1.
    @(negedge clk);
    rst_n = 1'b1; rsp_ready = 1'b1; req_valid = 4'b0010;
    req_a[1*W +: W] = 16'h0100; req_b[1*W +: W] = 16'h0200; req_op[1*3 +: 3] = 3'b000;
    #1;
    check("add_req_ready", 32'(req_ready), 32'h2);
    check("add_idle_busy", 32'(busy), 32'h0);
    @(negedge clk); req_valid = '0; #1;
    check("add_exec_busy", 32'(busy), 32'h1);
    check("add_exec_ready", 32'(req_ready), 32'h0);
    check("add_exec_rsp_valid", 32'(rsp_valid), 32'h0);
    check("add_alu_a", 32'(alu_a), 32'h0100);
    check("add_alu_b", 32'(alu_b), 32'h0200);
    @(negedge clk); #1;
    check("add_rsp_valid", 32'(rsp_valid), 32'h1);
    check("add_rsp_id", 32'(rsp_id), 32'h1);
    check("add_rsp_result", 32'(rsp_result), 32'h0300);
    check("add_rsp_flags", 32'(rsp_flags), 32'h0);
    @(negedge clk); #1;
    check("add_done_valid", 32'(rsp_valid), 32'h0);
    check("add_done_busy", 32'(busy), 32'h0);

    // MUL with negative operand from requester 0.
    req_valid = 4'b0001;
    req_a[0 +: W] = 16'h8200; req_b[0 +: W] = 16'h0300; req_op[0 +: 3] = 3'b010;
    #1;
    check("mul_req_ready", 32'(req_ready), 32'h1);
    @(negedge clk); req_valid = '0; #1;
    check("mul_alu_ctrl", 32'(alu_ctrl), 32'h2);
    @(negedge clk); #1;
    check("mul_rsp_valid", 32'(rsp_valid), 32'h1);
    check("mul_rsp_id", 32'(rsp_id), 32'h0);
    check("mul_rsp_result", 32'(rsp_result), 32'h8600);
    check("mul_rsp_flags", 32'(rsp_flags), 32'h8);

    // Reset applied while an op is in EXEC.
    @(negedge clk);
    load_all_operands();
    req_valid = 4'b0100;
    #1;
    check("mid_req_ready", 32'(req_ready), 32'h4);
    @(negedge clk); req_valid = '0; #1;
    check("mid_exec_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; req_valid = 4'hF;
    #1;
    check("mid_rsp_valid", 32'(rsp_valid), 32'h0);
    check("mid_busy", 32'(busy), 32'h0);
    check("mid_first_grant", 32'(req_ready), 32'h1);

    // Round-robin with all requesters pending: 0,1,2,3,0 then 1.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check("rr_exec_ready", 32'(req_ready), 32'h0);
      check("rr_exec_busy", 32'(busy), 32'h1);
      @(negedge clk); #1;
      check("rr_rsp_valid", 32'(rsp_valid), 32'h1);
      check("rr_rsp_id", 32'(rsp_id), 32'(k % 4));
      check("rr_rsp_result", 32'(rsp_result), 32'(16'h0110 * (k % 4 + 1)));
      check("rr_next_grant", 32'(req_ready), 32'(1 << ((k + 1) % 4)));
    end

    // Backpressure on the response of requester 1.
    @(negedge clk); rsp_ready = 1'b0; #1;
    check("bp_exec_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      check("bp_rsp_id", 32'(rsp_id), 32'h1);
      check("bp_rsp_result", 32'(rsp_result), 32'h0220);
      check("bp_rsp_flags", 32'(rsp_flags), 32'h0);
      check("bp_req_ready", 32'(req_ready), 32'h0);
    end
    @(negedge clk); rsp_ready = 1'b1; #1;
    check("bp_release_grant", 32'(req_ready), 32'h4);
    @(negedge clk); req_valid = '0; #1;
    check("op_forwarded", 32'(alu_ctrl), 32'h7);
    @(negedge clk); #1;
    check("unsup_rsp_id", 32'(rsp_id), 32'h2);
    check("unsup_rsp_result", 32'(rsp_result), 32'h0330);
    @(negedge clk); #1;
    check("final_idle", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
